forwarding_control: RTL and testbench

- Control end of the 16-bit pipeline forwarding path: generates the select/enable strobes (One_A, One_B, Two_A, Two_B, MW_One, MW_Two) consumed by the forwarding data mux.
- Tracks destination tags of the two instructions ahead of decode (EX slot, MEM slot) and compares them against decode-stage sources.
- Issues registered selects aligned to the instruction's EX cycle, and a load-use stall with bubble insertion.

---
 rtl/fwd_pkg.sv | 25 ++
 rtl/fwd_match.sv | 12 +
 rtl/forwarding_control.sv | 102 ++++++++++
 tb/tb_forwarding_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding control path: pipeline slot record,
// the registered select bundle and the default register-address width.
package fwd_pkg;

    localparam int FWD_REG_AW = 3;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] dest;
        logic                  wr_en;
        logic                  is_load;
    } slot_t;

    localparam slot_t BUBBLE_SLOT = '0;

    typedef struct packed {
        logic one_a;
        logic two_a;
        logic one_b;
        logic two_b;
        logic mw_one;
        logic mw_two;
    } sel_t;

endpackage

// File: rtl/fwd_match.sv
// Producer match: a live slot that writes a nonzero register equal to src.
module fwd_match
    import fwd_pkg::*;
(
    input  slot_t                 slot,
    input  logic [FWD_REG_AW-1:0] src,
    output logic                  hit
);

    assign hit = slot.valid & slot.wr_en & (slot.dest != '0) & (slot.dest == src);

endmodule

// File: rtl/forwarding_control.sv
// Forwarding select and load-use stall generation for the 16-bit pipeline.
// Optional FWD_STATS_EN adds saturating stall_cnt / fwd_cnt event counters.
module forwarding_control
    import fwd_pkg::*;
#(
    // Slot dest width comes from fwd_pkg, so REG_AW must equal FWD_REG_AW.
    parameter int REG_AW = FWD_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src_a,
    input  logic [REG_AW-1:0] id_src_b,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              flush,
    output logic              stall,
    output logic              One_A,
    output logic              One_B,
    output logic              Two_A,
    output logic              Two_B,
    output logic              MW_One,
    output logic              MW_Two
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       fwd_cnt
`endif
);

    slot_t ex_slot, mem_slot, ex_next;
    sel_t  sel_q, sel_next;
    logic  ex_a, ex_b, mem_a, mem_b;
    logic  advance;

    fwd_match u_match_ex_a  (.slot(ex_slot),  .src(id_src_a), .hit(ex_a));
    fwd_match u_match_ex_b  (.slot(ex_slot),  .src(id_src_b), .hit(ex_b));
    fwd_match u_match_mem_a (.slot(mem_slot), .src(id_src_a), .hit(mem_a));
    fwd_match u_match_mem_b (.slot(mem_slot), .src(id_src_b), .hit(mem_b));

    assign stall   = id_valid & ~flush & ex_slot.is_load & (ex_a | ex_b);
    assign advance = id_valid & ~stall & ~flush;

    always_comb begin
        ex_next  = BUBBLE_SLOT;
        sel_next = '0;
        if (advance) begin
            ex_next.valid   = 1'b1;
            ex_next.dest    = id_dest;
            ex_next.wr_en   = id_wr_en;
            ex_next.is_load = id_is_load;
            // Most recent producer (EX) wins over the older one (MEM).
            sel_next.one_a  = ex_a;
            sel_next.two_a  = mem_a & ~ex_a;
            if (id_is_store) begin
                sel_next.mw_one = ex_b;
                sel_next.mw_two = mem_b & ~ex_b;
            end else begin
                sel_next.one_b  = ex_b;
                sel_next.two_b  = mem_b & ~ex_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_slot  <= BUBBLE_SLOT;
            mem_slot <= BUBBLE_SLOT;
            sel_q    <= '0;
        end else begin
            mem_slot <= ex_slot;
            ex_slot  <= ex_next;
            sel_q    <= sel_next;
        end
    end

    assign One_A  = sel_q.one_a;
    assign Two_A  = sel_q.two_a;
    assign One_B  = sel_q.one_b;
    assign Two_B  = sel_q.two_b;
    assign MW_One = sel_q.mw_one;
    assign MW_Two = sel_q.mw_two;

`ifdef FWD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if ((|sel_next) && fwd_cnt != 16'hFFFF)
                fwd_cnt <= fwd_cnt + 16'd1;
        end
    end
`else
    // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_forwarding_control.sv
// Directed bench for forwarding_control: expected selects are queued when an
// instruction is presented in decode and checked after the following edge.
module tb_forwarding_control;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_src_a, id_src_b, id_dest;
    logic       id_wr_en, id_is_load, id_is_store, flush;
    logic       stall;
    logic       One_A, One_B, Two_A, Two_B, MW_One, MW_Two;
`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt, fwd_cnt;
    int          exp_stall_cnt = 0;
    int          exp_fwd_cnt   = 0;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];

    forwarding_control #(.REG_AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_src_a   (id_src_a),
        .id_src_b   (id_src_b),
        .id_dest    (id_dest),
        .id_wr_en   (id_wr_en),
        .id_is_load (id_is_load),
        .id_is_store(id_is_store),
        .flush      (flush),
        .stall      (stall),
        .One_A      (One_A),
        .One_B      (One_B),
        .Two_A      (Two_A),
        .Two_B      (Two_B),
        .MW_One     (MW_One),
        .MW_Two     (MW_Two)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Observed order: {One_A, Two_A, One_B, Two_B, MW_One, MW_Two}
    function automatic logic [5:0] obs_sel();
        return {One_A, Two_A, One_B, Two_B, MW_One, MW_Two};
    endfunction

    task automatic drive(input logic v, input int a, input int b, input int d,
                         input logic we, input logic ld, input logic st, input logic fl);
        id_valid    = v;
        id_src_a    = a[2:0];
        id_src_b    = b[2:0];
        id_dest     = d[2:0];
        id_wr_en    = we;
        id_is_load  = ld;
        id_is_store = st;
        flush       = fl;
    endtask

    task automatic edge_and_check(input string tag);
        logic [5:0] e;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s queue: observed empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            assert (obs_sel() === e) else begin
                errors++;
                $error("FAIL %s sel: observed %b expected %b", tag, obs_sel(), e);
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic v, input int a, input int b,
                       input int d, input logic we, input logic ld, input logic st,
                       input logic fl, input logic es, input logic [5:0] esel);
        drive(v, a, b, d, we, ld, st, fl);
        #1;
        checks++;
        assert (stall === es) else begin
            errors++;
            $error("FAIL %s stall: observed %b expected %b", tag, stall, es);
        end
        exp_q.push_back(esel);
`ifdef FWD_STATS_EN
        if (rst_n) begin
            if (es) exp_stall_cnt++;
            if (esel != 6'b0) exp_fwd_cnt++;
        end else begin
            exp_stall_cnt = 0;
            exp_fwd_cnt   = 0;
        end
`endif
        edge_and_check(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // reset held two cycles with a live load in decode
        drive(1'b1, 3, 0, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(6'b000000);
        edge_and_check("rst1");
        cyc("rst2",   1, 3, 0, 3, 1, 1, 0, 0, 0, 6'b000000);
        rst_n = 1'b1;
        cyc("norst",  1, 3, 3, 1, 1, 0, 0, 0, 0, 6'b000000);

        // back-to-back ALU forwarding
        cyc("add_r3", 1, 1, 0, 3, 1, 0, 0, 0, 0, 6'b100000);
        cyc("sub",    1, 3, 0, 4, 1, 0, 0, 0, 0, 6'b100000);
        cyc("and_b",  1, 0, 3, 5, 1, 0, 0, 0, 0, 6'b000100);

        // reset mid-stream must discard EX/MEM contents
        rst_n = 1'b0;
        cyc("mrst",   1, 5, 4, 2, 1, 0, 0, 0, 0, 6'b000000);
        rst_n = 1'b1;
        cyc("postrst",1, 5, 4, 2, 1, 0, 0, 0, 0, 6'b000000);

        // priority: two producers of r2, EX wins
        cyc("add_r2", 1, 0, 0, 2, 1, 0, 0, 0, 0, 6'b000000);
        cyc("or_prio",1, 2, 2, 7, 1, 0, 0, 0, 0, 6'b101000);

        // load-use: one stall cycle then Two_B from the load in MEM
        cyc("ld_r4",  1, 0, 0, 4, 1, 1, 0, 0, 0, 6'b000000);
        cyc("lu_stl", 1, 0, 4, 6, 1, 0, 0, 0, 1, 6'b000000);
        cyc("lu_fwd", 1, 0, 4, 6, 1, 0, 0, 0, 0, 6'b000100);

        // store data forwarding
        cyc("add_r5", 1, 0, 0, 5, 1, 0, 0, 0, 0, 6'b000000);
        cyc("st_one", 1, 0, 5, 0, 0, 0, 1, 0, 0, 6'b000010);
        cyc("add_r5b",1, 0, 0, 5, 1, 0, 0, 0, 0, 6'b000000);
        cyc("add_r1", 1, 0, 0, 1, 1, 0, 0, 0, 0, 6'b000000);
        cyc("st_two", 1, 0, 5, 0, 0, 0, 1, 0, 0, 6'b000001);
        cyc("st_a",   1, 1, 0, 0, 0, 0, 1, 0, 0, 6'b010000);

        // flush beats stall
        cyc("ld_r6",  1, 0, 0, 6, 1, 1, 0, 0, 0, 6'b000000);
        cyc("flush",  1, 6, 0, 1, 1, 0, 0, 1, 0, 6'b000000);
        cyc("aft_fl", 1, 6, 0, 1, 1, 0, 0, 0, 0, 6'b010000);

        // r0 never forwards or stalls
        cyc("ld_r0",  1, 0, 0, 0, 1, 1, 0, 0, 0, 6'b000000);
        cyc("use_r0", 1, 0, 0, 0, 1, 0, 0, 0, 0, 6'b000000);
        cyc("idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);

`ifdef FWD_STATS_EN
        checks++;
        assert (stall_cnt === 16'(exp_stall_cnt)) else begin
            errors++;
            $error("FAIL stall_cnt: observed %0d expected %0d", stall_cnt, exp_stall_cnt);
        end
        checks++;
        assert (fwd_cnt === 16'(exp_fwd_cnt)) else begin
            errors++;
            $error("FAIL fwd_cnt: observed %0d expected %0d", fwd_cnt, exp_fwd_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
